// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus bundle: instruction RAM read port plus the decoder-facing
// valid/ready channel. The fetch stage is the master of both.
interface riscv_fetch_if #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int INSN_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] inst_ram_address;
    logic                     inst_ram_read;
    logic [INSN_WIDTH-1:0]    inst_ram_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [INSN_WIDTH-1:0]    out_insn;
    logic [ADDRESS_WIDTH-1:0] out_pc;

    modport master (
        output inst_ram_address,
        output inst_ram_read,
        input  inst_ram_data,
        output out_valid,
        input  out_ready,
        output out_insn,
        output out_pc
    );

    modport slave (
        input  inst_ram_address,
        input  inst_ram_read,
        output inst_ram_data,
        input  out_valid,
        output out_ready,
        input  out_insn,
        input  out_pc
    );
endinterface

// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: PC generation, 1-cycle-latency instruction RAM reads,
// and a 2-entry skid queue feeding the decoder, with redirect and halt support.
module riscv_fetch #(
    parameter int                       ADDRESS_WIDTH = 24,
    parameter int                       INSN_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    riscv_fetch_if.master            bus,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt,
    output logic                     busy
);

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;
    logic                     inflight;
    logic                     kill;

    logic [INSN_WIDTH-1:0]    q_insn [2];
    logic [ADDRESS_WIDTH-1:0] q_pc   [2];
    logic                     head;
    logic [1:0]               count;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic                     tail;
    logic [2:0]               credit;

    assign pop    = (count != 2'd0) && bus.out_ready;
    // Reads already committed (queued or in flight) after this cycle's pop;
    // a new read is only allowed if its response is guaranteed a slot.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = reset_n && !halt && !redirect && (credit < 3'd2);
    assign push   = inflight && !kill && !redirect;
    assign tail   = head ^ count[0];

    assign bus.inst_ram_read    = issue;
    assign bus.inst_ram_address = fetch_pc;
    assign bus.out_valid        = (count != 2'd0);
    assign bus.out_insn         = q_insn[head];
    assign bus.out_pc           = q_pc[head];
    assign busy                 = inflight || (count != 2'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            head        <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_insn[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            inflight <= issue;
            kill     <= redirect && inflight;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight_pc <= fetch_pc;
            end
            // A redirect drops both the queue and any response returning now.
            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
                count    <= 2'd0;
                head     <= 1'b0;
            end else begin
                if (push) begin
                    q_insn[tail] <= bus.inst_ram_data;
                    q_pc[tail]   <= inflight_pc;
                end
                if (pop) begin
                    head <= ~head;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed, table-driven bench for riscv_fetch: streaming, backpressure, redirect,
// halt, address wrap (8-bit instance) and asynchronous reset mid-stream.
module tb_riscv_fetch;

    localparam int AW = 24;
    localparam int IW = 32;

    typedef struct {
        logic          redirect;
        logic [AW-1:0] redirect_pc;
        logic          halt;
        logic          ready;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [IW-1:0] exp_insn;
        logic          exp_read;
        logic [AW-1:0] exp_addr;
        logic          exp_busy;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          busy;

    logic          w_redirect;
    logic [7:0]    w_redirect_pc;
    logic          w_halt;
    logic          w_busy;

    int checks = 0;
    int fails  = 0;

    vec_t vecs [31];

    always #5 clock = ~clock;

    riscv_fetch_if #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW)) bus ();
    riscv_fetch_if #(.ADDRESS_WIDTH(8),  .INSN_WIDTH(IW)) wbus ();

    riscv_fetch #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .RESET_PC('0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .busy        (busy)
    );

    riscv_fetch #(.ADDRESS_WIDTH(8), .INSN_WIDTH(IW), .RESET_PC('0)) dut_wrap (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (wbus),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .halt        (w_halt),
        .busy        (w_busy)
    );

    // Instruction RAM images: word at byte address a holds 0x13 + a/4.
    always @(posedge clock) begin
        if (bus.inst_ram_read)
            bus.inst_ram_data <= 32'h13 + 32'(bus.inst_ram_address >> 2);
        if (wbus.inst_ram_read)
            wbus.inst_ram_data <= 32'h13 + 32'(wbus.inst_ram_address >> 2);
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        redirect      = v.redirect;
        redirect_pc   = v.redirect_pc;
        halt          = v.halt;
        bus.out_ready = v.ready;
    endtask

    function automatic vec_t mk(input logic r, input logic [AW-1:0] rpc, input logic h,
                                input logic rdy, input logic ev, input logic [AW-1:0] epc,
                                input logic [IW-1:0] einsn, input logic erd,
                                input logic [AW-1:0] eaddr, input logic eb);
        vec_t v;
        v.redirect = r;   v.redirect_pc = rpc; v.halt = h;        v.ready = rdy;
        v.exp_valid = ev; v.exp_pc = epc;      v.exp_insn = einsn;
        v.exp_read = erd; v.exp_addr = eaddr;  v.exp_busy = eb;
        return v;
    endfunction

    // The queue must never hold more than two entries.
    always @(negedge clock) begin
        if (reset_n)
            check_output("count_bound", {31'd0, dut.count <= 2'd2}, 32'd1);
    end

    initial begin
        int k;
        logic [7:0]  wrap_pc   [4];
        logic [31:0] wrap_insn [4];

        //               redir rpc     halt rdy  valid pc      insn   read addr    busy
        vecs[0]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h0,   1'b0);
        vecs[1]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h4,   1'b1);
        vecs[2]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h0,   32'h13, 1'b1, 24'h8,   1'b1);
        vecs[3]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h4,   32'h14, 1'b1, 24'hC,   1'b1);
        vecs[4]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h8,   32'h15, 1'b1, 24'h10,  1'b1);
        vecs[5]  = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'hC,   32'h16, 1'b1, 24'h14,  1'b1);
        vecs[6]  = mk(1'b0, 24'h0,   1'b0, 1'b0, 1'b1, 24'h10,  32'h17, 1'b0, 24'h18,  1'b1);
        vecs[7]  = mk(1'b0, 24'h0,   1'b0, 1'b0, 1'b1, 24'h10,  32'h17, 1'b0, 24'h18,  1'b1);
        vecs[8]  = mk(1'b0, 24'h0,   1'b0, 1'b0, 1'b1, 24'h10,  32'h17, 1'b0, 24'h18,  1'b1);
        vecs[9]  = mk(1'b0, 24'h0,   1'b0, 1'b0, 1'b1, 24'h10,  32'h17, 1'b0, 24'h18,  1'b1);
        vecs[10] = mk(1'b0, 24'h0,   1'b0, 1'b0, 1'b1, 24'h10,  32'h17, 1'b0, 24'h18,  1'b1);
        vecs[11] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h10,  32'h17, 1'b1, 24'h18,  1'b1);
        vecs[12] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h14,  32'h18, 1'b1, 24'h1C,  1'b1);
        vecs[13] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h18,  32'h19, 1'b1, 24'h20,  1'b1);
        vecs[14] = mk(1'b1, 24'h103, 1'b0, 1'b1, 1'b1, 24'h1C,  32'h1A, 1'b0, 24'h24,  1'b1);
        vecs[15] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h100, 1'b0);
        vecs[16] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h104, 1'b1);
        vecs[17] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h100, 32'h53, 1'b1, 24'h108, 1'b1);
        vecs[18] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b1, 24'h104, 32'h54, 1'b0, 24'h10C, 1'b1);
        vecs[19] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b1, 24'h108, 32'h55, 1'b0, 24'h10C, 1'b1);
        vecs[20] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h0,   32'h0,  1'b0, 24'h10C, 1'b0);
        vecs[21] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h0,   32'h0,  1'b0, 24'h10C, 1'b0);
        vecs[22] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h10C, 1'b0);
        vecs[23] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h110, 1'b1);
        vecs[24] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h10C, 32'h56, 1'b1, 24'h114, 1'b1);
        vecs[25] = mk(1'b1, 24'h200, 1'b1, 1'b1, 1'b1, 24'h110, 32'h57, 1'b0, 24'h118, 1'b1);
        vecs[26] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h0,   32'h0,  1'b0, 24'h200, 1'b0);
        vecs[27] = mk(1'b0, 24'h0,   1'b1, 1'b1, 1'b0, 24'h0,   32'h0,  1'b0, 24'h200, 1'b0);
        vecs[28] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h200, 1'b0);
        vecs[29] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b0, 24'h0,   32'h0,  1'b1, 24'h204, 1'b1);
        vecs[30] = mk(1'b0, 24'h0,   1'b0, 1'b1, 1'b1, 24'h200, 32'h93, 1'b1, 24'h208, 1'b1);

        wrap_pc[0] = 8'hF8; wrap_insn[0] = 32'h51;
        wrap_pc[1] = 8'hFC; wrap_insn[1] = 32'h52;
        wrap_pc[2] = 8'h00; wrap_insn[2] = 32'h13;
        wrap_pc[3] = 8'h04; wrap_insn[3] = 32'h14;

        redirect       = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        bus.out_ready  = 1'b0;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;
        w_halt         = 1'b1;
        wbus.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("reset_read",  {31'd0, bus.inst_ram_read}, 32'd0);
        check_output("reset_busy",  {31'd0, busy}, 32'd0);
        check_output("reset_addr",  32'(bus.inst_ram_address), 32'h0);
        check_output("reset_insn",  bus.out_insn, 32'h0);
        check_output("reset_pc",    32'(bus.out_pc), 32'h0);

        // Each vector covers one clock cycle: drive just after the edge, sample mid-cycle.
        for (int i = 0; i < 31; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) reset_n = 1'b1;
            apply_stimulus(vecs[i]);
            @(negedge clock);
            check_output($sformatf("v%0d valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].exp_valid});
            check_output($sformatf("v%0d read", i),  {31'd0, bus.inst_ram_read}, {31'd0, vecs[i].exp_read});
            check_output($sformatf("v%0d addr", i),  32'(bus.inst_ram_address), 32'(vecs[i].exp_addr));
            check_output($sformatf("v%0d busy", i),  {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            if (vecs[i].exp_valid) begin
                check_output($sformatf("v%0d pc", i),   32'(bus.out_pc), 32'(vecs[i].exp_pc));
                check_output($sformatf("v%0d insn", i), bus.out_insn, vecs[i].exp_insn);
            end
        end

        // Asynchronous reset asserted between clock edges while streaming.
        @(posedge clock);
        #2;
        check_output("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("async_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("async_busy",  {31'd0, busy}, 32'd0);
        check_output("async_read",  {31'd0, bus.inst_ram_read}, 32'd0);
        check_output("async_addr",  32'(bus.inst_ram_address), 32'h0);
        check_output("async_insn",  bus.out_insn, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_output("restart_read0", {31'd0, bus.inst_ram_read}, 32'd1);
        check_output("restart_addr0", 32'(bus.inst_ram_address), 32'h0);
        check_output("restart_valid0", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clock);
        check_output("restart_addr1", 32'(bus.inst_ram_address), 32'h4);
        check_output("restart_valid1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clock);
        check_output("restart_valid2", {31'd0, bus.out_valid}, 32'd1);
        check_output("restart_pc2",    32'(bus.out_pc), 32'h0);
        check_output("restart_insn2",  bus.out_insn, 32'h13);

        // Wrap on the 8-bit instance: redirect near the top of the address space.
        @(posedge clock);
        #1;
        w_halt        = 1'b0;
        w_redirect    = 1'b1;
        w_redirect_pc = 8'hF8;
        @(posedge clock);
        #1;
        w_redirect = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (wbus.out_valid && k < 4) begin
                check_output($sformatf("wrap_pc%0d", k),   32'(wbus.out_pc), 32'(wrap_pc[k]));
                check_output($sformatf("wrap_insn%0d", k), wbus.out_insn, wrap_insn[k]);
                k++;
            end
        end
        check_output("wrap_outputs_seen", 32'(k), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
- Instruction fetch stage directly upstream of the RISC-V IMF decoder.
- Generates PCs, drives a synchronous instruction RAM with a fixed 1-cycle read latency, and buffers returned words in a 2-entry skid queue.
- Presents {insn, pc} to the decoder with a valid/ready handshake.
- Handles control-flow redirects from execute and a halt request.

Parameters:
- ADDRESS_WIDTH, 24: byte-address width of PC and instruction RAM address.
- INSN_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC fetched first after reset; low 2 bits must be zero.

Ports:
- clock  input  1  single clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- inst_ram_address  output  ADDRESS_WIDTH  byte address of the read, low 2 bits always 0.
- inst_ram_read  output  1  read strobe; data returns on the next cycle.
- inst_ram_data  input  INSN_WIDTH  read data, valid the cycle after inst_ram_read.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDRESS_WIDTH  new PC; low 2 bits ignored (forced 0).
- halt  input  1  level signal; inhibits new reads.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decoder accepts the head entry.
- out_insn  output  INSN_WIDTH  head instruction.
- out_pc  output  ADDRESS_WIDTH  PC of the head instruction.
- busy  output  1  read in flight or queue non-empty.

Behaviour:
- Reset: one clock, one reset (asynchronous, active-low); reset_n low clears all state immediately, independent of clock.
  - fetch_pc = RESET_PC; queue count = 0; in-flight flag = 0; kill flag = 0; queue entries = 0.
  - Outputs during reset: out_valid=0, out_insn=0, out_pc=0, inst_ram_read=0, inst_ram_address=RESET_PC, busy=0.
- State:
  - fetch_pc register.
  - inflight: read issued last cycle.
  - inflight_pc.
  - kill: discard the in-flight response.
  - 2-entry FIFO of {insn, pc} with head pointer and count (0..2).
- pop = out_valid & out_ready.
- Issue condition (combinational): reset_n & !halt & !redirect & (count + inflight - pop < 2).
  - When true: inst_ram_read=1, inst_ram_address=fetch_pc; next fetch_pc = fetch_pc + 4, wrapping mod 2^ADDRESS_WIDTH; next inflight=1, inflight_pc=fetch_pc.
  - When false: inflight goes to 0.
- Throughput: sustained 1 instruction/cycle with out_ready held high. First out_valid appears 2 cycles after the issue cycle (read cycle, response cycle, then registered into the queue).
- Response: in the cycle after issue, if inflight & !kill & !redirect, push {inst_ram_data, inflight_pc}. Push and pop may occur in the same cycle; count is unchanged.
- Queue overflow is impossible by the credit rule; the bench asserts count <= 2 always.
- Redirect (single-cycle pulse, may be repeated):
  - Next cycle: count=0; fetch_pc = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}; kill = inflight.
  - No read is issued in the redirect cycle.
  - First read at the new PC is issued the cycle after redirect, so the new-path out_valid appears 3 cycles after the redirect cycle.
  - kill clears after one cycle; the response arriving while kill=1 is discarded.
- Redirect coincident with pop: redirect wins; the popped entry is consumed by the decoder; all other entries are flushed.
- Redirect coincident with a returning response: the response is dropped.
- Redirect while halt=1: fetch_pc is updated, the queue flushes, and no read occurs until halt deasserts.
- Halt:
  - Stops new reads only.
  - The in-flight read completes and is enqueued.
  - The queue continues to drain.
  - fetch_pc is held.
- out_valid = (count != 0). out_insn/out_pc reflect the head entry and are stable while out_valid & !out_ready (no redirect).
- busy = inflight | (count != 0).
- Reset mid-operation: all state clears asynchronously. No read strobe is emitted while reset_n is low. The first read at RESET_PC occurs on the first clock edge after reset_n rises.

Test Plan:
- Streaming: RESET_PC=0, RAM[i]=0x00000013+i, out_ready=1 → out_pc 0,4,8,… on consecutive cycles, out_insn matching; first out_valid on cycle 2 after reset release.
- Backpressure: out_ready=0 for 5 cycles mid-stream → count saturates at 2, inst_ram_read=0, head stable at e.g. pc=0x10; on release the next outputs are 0x10, 0x14, 0x18 with no gap or duplicate.
- Redirect: redirect=1, redirect_pc=0x103 while a read at 0x20 is in flight → the 0x20 response is dropped, next out_pc=0x100 exactly 3 cycles later, no stale entries.
- Halt: halt=1 with count=1, inflight=1 → two more outputs, then out_valid=0, busy=0, inst_ram_read stays 0; releasing halt resumes at the held fetch_pc.
- Wrap: ADDRESS_WIDTH=8, redirect_pc=0xF8 → out_pc sequence 0xF8, 0xFC, 0x00, 0x04.
- Async reset mid-stream: reset_n low between clock edges → out_valid, busy, and inst_ram_read drop immediately; after release the fetch restarts at RESET_PC.
